// File: rtl/dda_stream_sender_if.sv
// Ray-result input bus and AXI-Stream output bus of the DDA-out sender.
// master = the sender block, slave = its environment (DDA core + DDA-out FIFO).
interface dda_stream_sender_if;
  logic        dda_valid_in;
  logic        dda_ready_out;
  logic [8:0]  dda_col_in;
  logic [3:0]  dda_map_in;
  logic [8:0]  dda_height_in;
  logic        dda_side_in;
  logic [15:0] dda_wallx_in;
  logic        fifo_tvalid_out;
  logic        fifo_tready_in;
  logic [38:0] fifo_tdata_out;
  logic        fifo_tlast_out;

  modport master (
    input  dda_valid_in, dda_col_in, dda_map_in, dda_height_in, dda_side_in, dda_wallx_in,
    output dda_ready_out,
    output fifo_tvalid_out, fifo_tdata_out, fifo_tlast_out,
    input  fifo_tready_in
  );

  modport slave (
    output dda_valid_in, dda_col_in, dda_map_in, dda_height_in, dda_side_in, dda_wallx_in,
    input  dda_ready_out,
    input  fifo_tvalid_out, fifo_tdata_out, fifo_tlast_out,
    output fifo_tready_in
  );
endinterface

// File: rtl/dda_stream_sender.sv
// DDA-out stream sender: packs ray results, buffers DEPTH words, streams them with tlast on the last column.
// Optional column-order checker compiled in with DDA_SENDER_ORDER_CHECK_EN.
module dda_stream_sender #(
  parameter int unsigned SCREEN_WIDTH = 320,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                 pixel_clk_in,
  input  logic                 rst_in,
  dda_stream_sender_if.master  bus,
  output logic                 frame_done_out,
  output logic                 order_err_out
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [9:0]  WIDTH10 = 10'(SCREEN_WIDTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef enum logic {STREAM, LAST_SENT} frame_state_t;

  logic [38:0]      mem_data [DEPTH];
  logic [DEPTH-1:0] mem_last;
  ptr_t             wr_ptr;
  ptr_t             rd_ptr;
  logic [CNT_W-1:0] count;
  logic             ready;
  logic             tvalid;
  logic             push;
  logic             pop;
  logic             in_last;
  frame_state_t     state;
  frame_state_t     state_next;

  // Ready comes only from the count, so a pop at full does not admit a word in the same cycle.
  assign ready   = (count != CNT_W'(DEPTH));
  assign tvalid  = (count != '0);
  assign push    = bus.dda_valid_in && ready;
  assign pop     = tvalid && bus.fifo_tready_in;
  assign in_last = ({1'b0, bus.dda_col_in} == WIDTH10 - 10'd1);

  assign bus.dda_ready_out   = ready;
  assign bus.fifo_tvalid_out = tvalid;
  assign bus.fifo_tdata_out  = mem_data[rd_ptr];
  assign bus.fifo_tlast_out  = mem_last[rd_ptr];

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      mem_last <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_data[i] <= '0;
      end
    end else begin
      if (push) begin
        mem_data[wr_ptr] <= {bus.dda_col_in, bus.dda_map_in, bus.dda_height_in,
                             bus.dda_side_in, bus.dda_wallx_in};
        mem_last[wr_ptr] <= in_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= STREAM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    frame_done_out = 1'b0;
    case (state)
      STREAM: begin
        if (pop && bus.fifo_tlast_out) begin
          state_next     = LAST_SENT;
          frame_done_out = 1'b1;
        end
      end
      // Next pop or one idle cycle both return here, so the stay lasts exactly one cycle.
      LAST_SENT: state_next = STREAM;
      default:   state_next = STREAM;
    endcase
  end

`ifdef DDA_SENDER_ORDER_CHECK_EN
  logic [8:0] exp_col;
  logic       order_err;

  always_ff @(posedge pixel_clk_in or negedge rst_in) begin
    if (!rst_in) begin
      exp_col   <= '0;
      order_err <= 1'b0;
    end else if (push) begin
      if ((bus.dda_col_in != exp_col) || ({1'b0, bus.dda_col_in} >= WIDTH10)) begin
        order_err <= 1'b1;
      end
      // Resync to the received column so one glitch does not flag every later ray.
      if ({1'b0, bus.dda_col_in} >= WIDTH10 - 10'd1) begin
        exp_col <= '0;
      end else begin
        exp_col <= bus.dda_col_in + 1'b1;
      end
    end
  end

  assign order_err_out = order_err;
`else
  assign order_err_out = 1'b0;
`endif

endmodule
